// File: rtl/loader_write_scheduler_pkg.sv
// Shared constants for the game-loader SDRAM write path.
package loader_write_scheduler_pkg;

  localparam int unsigned LOADER_ADDR_W = 22;
  localparam int unsigned LOADER_DATA_W = 8;

  // nes_ce phase at which the SDRAM port-A slot opens
  localparam logic [1:0] NES_CE_SLOT = 2'd3;

endpackage

// File: rtl/loader_write_scheduler_fifo.sv
// Synchronous FIFO buffering loader writes; control state is reset, storage is not.
module loader_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  // a pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clear;

  // Storage write at the tail; contents need no reset
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/loader_write_scheduler.sv
// Queues game-loader writes and issues one per NES SDRAM slot, each held a full nes_ce period.
module loader_write_scheduler
  import loader_write_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = LOADER_ADDR_W,
  parameter int unsigned DATA_W = LOADER_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             nes_ce,
  input  logic                   clear,
  input  logic                   load_done,
  input  logic                   in_write,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_din,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic                   r_mem_we;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_din;
  logic                   r_overflow;
  logic                   w_slot;
  logic                   w_push_req;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [ENT_W-1:0]       w_head;
  logic [$clog2(DEPTH):0] w_level;

  assign w_slot     = (nes_ce == NES_CE_SLOT);
  assign w_push_req = in_write & ~load_done & ~clear;
  // pop decision uses pre-edge state, so a push into an empty FIFO waits for the next slot
  assign w_pop      = w_slot & ~w_empty & ~clear;
  assign w_drop     = w_push_req & w_full & ~w_pop;

  loader_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_clear (clear),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_wdata ({in_addr, in_data}),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Port-A write registers change only at slot edges; overflow is sticky
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_mem_we   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_slot) begin
        r_mem_we <= ~w_empty;
        if (!w_empty) {r_mem_addr, r_mem_din} <= w_head;
      end
    end
  end

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign level    = w_level;
  assign overflow = r_overflow;
  assign busy     = (w_level != '0) | r_mem_we;

endmodule
